// File: rtl/mdiv_issue_latch_pkg.sv
// mdiv_issue_latch_pkg: state encodings and counter sizing shared by the mult/div issue stage.
package mdiv_issue_latch_pkg;
  localparam logic [1:0] MDIV_IDLE = 2'd0;
  localparam logic [1:0] MDIV_RUN  = 2'd1;
  localparam logic [1:0] MDIV_DONE = 2'd2;
  function automatic int mdiv_cnt_w(input int max_cycles);
    return $clog2(max_cycles + 1);
  endfunction
endpackage

// File: rtl/mdiv_issue_latch_if.sv
// mdiv_issue_latch_if: decode/multdiv/writeback signals of the mult/div issue stage.
interface mdiv_issue_latch_if #(
  parameter int DATA_W = 32,
  parameter int IR_W   = 32,
  parameter int CNT_W  = 6
);
  logic              ctrl_mult;
  logic              ctrl_div;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [IR_W-1:0]   ir;
  logic              result_ready;
  logic [DATA_W-1:0] result_in;
  logic              exception_in;
  logic              result_ack;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [IR_W-1:0]   out_ir;
  logic              out_is_div;
  logic              op_start;
  logic              is_running;
  logic              stall;
  logic              result_valid;
  logic [DATA_W-1:0] result_out;
  logic              exception_out;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_count;
  modport master (
    output ctrl_mult, ctrl_div, a, b, ir, result_ready, result_in, exception_in, result_ack,
    input  out_a, out_b, out_ir, out_is_div, op_start, is_running, stall, result_valid,
           result_out, exception_out, timeout, cycle_count
  );
  modport slave (
    input  ctrl_mult, ctrl_div, a, b, ir, result_ready, result_in, exception_in, result_ack,
    output out_a, out_b, out_ir, out_is_div, op_start, is_running, stall, result_valid,
           result_out, exception_out, timeout, cycle_count
  );
endinterface

// File: rtl/mdiv_cycle_ctr.sv
// mdiv_cycle_ctr: saturating RUN-cycle counter with synchronous clear and limit flag.
module mdiv_cycle_ctr #(
  parameter int LIMIT = 40,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);
  assign at_limit = count == CNT_W'(LIMIT);
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (en && !at_limit) count <= count + 1'b1;
endmodule

// File: rtl/mdiv_issue_latch.sv
// mdiv_issue_latch: captures a mult/div request, tracks it through RUN with a watchdog,
// and holds the result until writeback acknowledges it.
module mdiv_issue_latch
  import mdiv_issue_latch_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IR_W       = 32,
  parameter int MAX_CYCLES = 40
) (
  input logic clock,
  input logic reset,
  mdiv_issue_latch_if.slave bus
);
  localparam int CNT_W = mdiv_cnt_w(MAX_CYCLES);
  logic [1:0]        state;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [IR_W-1:0]   ir_q;
  logic              div_q, exc_q, to_q, start_q;
  logic              req, run, at_limit, fin_ok, fin_to;
  logic [CNT_W-1:0]  count;
  assign req    = bus.ctrl_mult | bus.ctrl_div;
  assign run    = state == MDIV_RUN;
  // a new request always wins over a result arriving in the same cycle
  assign fin_ok = run & ~req & bus.result_ready;
  assign fin_to = run & ~req & ~bus.result_ready & at_limit;
  mdiv_cycle_ctr #(.LIMIT(MAX_CYCLES), .CNT_W(CNT_W)) u_ctr (
    .clock    (clock),
    .reset    (reset),
    .clr      (req),
    .en       (run & ~bus.result_ready),
    .count    (count),
    .at_limit (at_limit)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state   <= MDIV_IDLE;
      start_q <= 1'b0;
    end else begin
      start_q <= req;
      state   <= req ? MDIV_RUN :
                 (fin_ok | fin_to) ? MDIV_DONE :
                 (state == MDIV_DONE && bus.result_ack) ? MDIV_IDLE : state;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      ir_q  <= '0;
      div_q <= 1'b0;
    end else if (req) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      ir_q  <= bus.ir;
      div_q <= bus.ctrl_div & ~bus.ctrl_mult;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset || req) begin
      res_q <= '0;
      exc_q <= 1'b0;
      to_q  <= 1'b0;
    end else if (fin_ok) begin
      res_q <= bus.result_in;
      exc_q <= bus.exception_in;
    end else if (fin_to) begin
      res_q <= '0;
      exc_q <= 1'b1;
      to_q  <= 1'b1;
    end
  assign bus.out_a         = a_q;
  assign bus.out_b         = b_q;
  assign bus.out_ir        = ir_q;
  assign bus.out_is_div    = div_q;
  assign bus.op_start      = start_q;
  assign bus.is_running    = run;
  assign bus.result_valid  = state == MDIV_DONE;
  assign bus.stall         = run | (bus.result_valid & ~bus.result_ack);
  assign bus.result_out    = res_q;
  assign bus.exception_out = exc_q;
  assign bus.timeout       = to_q;
  assign bus.cycle_count   = count;
endmodule

// File: tb/tb_mdiv_issue_latch.sv
// tb_mdiv_issue_latch: directed stimulus, per-cycle comparison against a behavioural model.
module tb_mdiv_issue_latch;
  localparam int MAX = 40;
  localparam int CW  = $clog2(MAX + 1);
  logic clk, rst;
  int checks = 0, failures = 0;
  mdiv_issue_latch_if #(.DATA_W(32), .IR_W(32), .CNT_W(CW)) bus ();
  mdiv_issue_latch #(.DATA_W(32), .IR_W(32), .MAX_CYCLES(MAX)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // model: an operation is busy, finished, or absent; plain integer cycle count
  bit m_busy, m_fin, m_div, m_exc, m_to, m_start;
  int m_cnt;
  logic [31:0] m_a, m_b, m_ir, m_res;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {m_busy, m_fin, m_div, m_exc, m_to, m_start} = '0;
      m_cnt = 0; m_a = 0; m_b = 0; m_ir = 0; m_res = 0;
    end else begin
      m_start = bus.ctrl_mult || bus.ctrl_div;
      if (m_start) begin
        m_a = bus.a; m_b = bus.b; m_ir = bus.ir;
        m_div = bus.ctrl_div && !bus.ctrl_mult;
        m_busy = 1; m_fin = 0; m_cnt = 0; m_res = 0; m_exc = 0; m_to = 0;
      end else if (m_busy) begin
        if (bus.result_ready) begin
          m_res = bus.result_in; m_exc = bus.exception_in; m_busy = 0; m_fin = 1;
        end else if (m_cnt >= MAX) begin
          m_res = 0; m_exc = 1; m_to = 1; m_busy = 0; m_fin = 1;
        end else m_cnt++;
      end else if (m_fin && bus.result_ack) m_fin = 0;
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("m_out_a", 64'(bus.out_a), 64'(m_a));
    chk("m_out_b", 64'(bus.out_b), 64'(m_b));
    chk("m_out_ir", 64'(bus.out_ir), 64'(m_ir));
    chk("m_is_div", 64'(bus.out_is_div), 64'(m_div));
    chk("m_op_start", 64'(bus.op_start), 64'(m_start));
    chk("m_running", 64'(bus.is_running), 64'(m_busy));
    chk("m_valid", 64'(bus.result_valid), 64'(m_fin));
    chk("m_stall", 64'(bus.stall), 64'(m_busy || (m_fin && bus.result_ack !== 1'b1)));
    chk("m_result", 64'(bus.result_out), 64'(m_res));
    chk("m_exc", 64'(bus.exception_out), 64'(m_exc));
    chk("m_timeout", 64'(bus.timeout), 64'(m_to));
    chk("m_count", 64'(bus.cycle_count), 64'(m_cnt));
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic issue(input bit m, input bit d, input logic [31:0] av, bv, irv);
    bus.ctrl_mult = m; bus.ctrl_div = d; bus.a = av; bus.b = bv; bus.ir = irv;
    step(1);
    bus.ctrl_mult = 0; bus.ctrl_div = 0;
  endtask
  task automatic finish_with(input logic [31:0] r, input bit e);
    bus.result_ready = 1; bus.result_in = r; bus.exception_in = e;
    step(1);
    bus.result_ready = 0; bus.exception_in = 0;
  endtask
  task automatic ack();
    bus.result_ack = 1;
    step(1);
    bus.result_ack = 0;
  endtask
  initial begin
    rst = 1;
    {bus.ctrl_mult, bus.ctrl_div, bus.result_ready, bus.exception_in, bus.result_ack} = '0;
    bus.a = 0; bus.b = 0; bus.ir = 0; bus.result_in = 0;
    #1;
    chk("rst_stall", 64'(bus.stall), 0);
    chk("rst_valid", 64'(bus.result_valid), 0);
    chk("rst_count", 64'(bus.cycle_count), 0);
    @(posedge clk); #1; rst = 0;
    step(1);
    issue(1, 0, 7, 6, 32'h11);
    chk("mul_start", 64'(bus.op_start), 1);
    chk("mul_count0", 64'(bus.cycle_count), 0);
    step(1);
    chk("mul_start_gone", 64'(bus.op_start), 0);
    step(4);
    chk("mul_count5", 64'(bus.cycle_count), 5);
    finish_with(42, 0);
    chk("mul_valid", 64'(bus.result_valid), 1);
    chk("mul_result", 64'(bus.result_out), 42);
    chk("mul_held_count", 64'(bus.cycle_count), 5);
    step(2);
    chk("mul_stall_hold", 64'(bus.stall), 1);
    ack();
    chk("mul_idle", 64'(bus.result_valid), 0);
    chk("mul_keep_a", 64'(bus.out_a), 7);
    issue(0, 1, 10, 0, 32'h22);
    step(2);
    finish_with(32'hffff_ffff, 1);
    chk("div0_exc", 64'(bus.exception_out), 1);
    chk("div0_to", 64'(bus.timeout), 0);
    ack();
    issue(0, 1, 100, 7, 32'h33);
    step(40);
    chk("wd_running", 64'(bus.is_running), 1);
    chk("wd_count", 64'(bus.cycle_count), MAX);
    step(1);
    chk("wd_valid", 64'(bus.result_valid), 1);
    chk("wd_timeout", 64'(bus.timeout), 1);
    chk("wd_exc", 64'(bus.exception_out), 1);
    chk("wd_result", 64'(bus.result_out), 0);
    step(2);
    ack();
    issue(1, 0, 1, 2, 32'h44);
    step(3);
    chk("rs_count3", 64'(bus.cycle_count), 3);
    issue(0, 1, 9, 3, 32'h55);
    chk("rs_a", 64'(bus.out_a), 9);
    chk("rs_div", 64'(bus.out_is_div), 1);
    chk("rs_count0", 64'(bus.cycle_count), 0);
    chk("rs_start", 64'(bus.op_start), 1);
    step(2);
    bus.result_ready = 1; bus.result_in = 99;
    issue(1, 0, 5, 5, 32'h66);
    bus.result_ready = 0;
    chk("race_valid", 64'(bus.result_valid), 0);
    chk("race_run", 64'(bus.is_running), 1);
    chk("race_a", 64'(bus.out_a), 5);
    step(1);
    finish_with(25, 0);
    chk("race_result", 64'(bus.result_out), 25);
    issue(1, 1, 3, 4, 32'h77);
    chk("both_is_mult", 64'(bus.out_is_div), 0);
    chk("done_discard", 64'(bus.result_out), 0);
    finish_with(12, 0);
    ack();
    finish_with(77, 0);
    chk("idle_rr_valid", 64'(bus.result_valid), 0);
    chk("idle_rr_result", 64'(bus.result_out), 12);
    issue(0, 1, 8, 2, 32'h88);
    #2 rst = 1;
    #1;
    chk("arst_start", 64'(bus.op_start), 0);
    chk("arst_stall", 64'(bus.stall), 0);
    chk("arst_a", 64'(bus.out_a), 0);
    step(1);
    rst = 0;
    step(1);
    ack();
    chk("ack_idle_valid", 64'(bus.result_valid), 0);
    chk("ack_idle_run", 64'(bus.is_running), 0);
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
